// File: rtl/vram_arb_if.sv
// VRAM arbiter bundle: CPU request port, video scanout port and the single-port RAM side.
// master = requesters plus RAM model, slave = the arbiter.
interface vram_arb_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_rdy;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_dout;
  logic              vid_valid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, ram_rdata,
    input  cpu_dout, cpu_rdy, vid_dout, vid_valid, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, vid_req, vid_addr, ram_rdata,
    output cpu_dout, cpu_rdy, vid_dout, vid_valid, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video fetches always win (data two edges after request), CPU completes grant+2.
// Define VRAM_ARB_WBUF_EN to post CPU writes into a one-entry buffer (cpu_rdy one edge after accept).
module vram_arb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic      i_clk,
  input  logic      i_reset,
  vram_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUED, DONE} cpu_st_t;

  cpu_st_t           r_cpu_st;
  logic              r_cpu_we;
  logic              r_vid_s1;
  logic              r_vid_s2;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_cpu_rdy;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_cpu_dout;
  logic [DATA_W-1:0] r_vid_dout;
  logic              w_cpu_free;
  logic              w_cpu_grant;
`ifdef VRAM_ARB_WBUF_EN
  logic              r_wb_vld;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              w_wb_post;
`endif

  // r_cpu_rdy masks cpu_req in the cycle the requester is still seeing its completion.
  assign w_cpu_free = (r_cpu_st == IDLE) && bus.cpu_req && !r_cpu_rdy;
`ifdef VRAM_ARB_WBUF_EN
  assign w_wb_post   = w_cpu_free && !r_wb_vld && bus.cpu_we;
  assign w_cpu_grant = w_cpu_free && !r_wb_vld && !bus.cpu_we && !bus.vid_req;
`else
  assign w_cpu_grant = w_cpu_free && !bus.vid_req;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cpu_st    <= IDLE;
      r_cpu_we    <= 1'b0;
      r_vid_s1    <= 1'b0;
      r_vid_s2    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_rdy   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_cpu_dout  <= '0;
      r_vid_dout  <= '0;
`ifdef VRAM_ARB_WBUF_EN
      r_wb_vld    <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
`endif
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_cpu_rdy   <= 1'b0;
      r_vid_s1    <= bus.vid_req;
      r_vid_s2    <= r_vid_s1;
      r_vid_valid <= r_vid_s2;
      if (r_vid_s2) begin
        r_vid_dout <= bus.ram_rdata;
      end

      // One RAM slot per edge: video first, then a buffered write, then the CPU engine.
      if (bus.vid_req) begin
        r_ram_en   <= 1'b1;
        r_ram_addr <= bus.vid_addr;
      end
`ifdef VRAM_ARB_WBUF_EN
      else if (r_wb_vld) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= r_wb_addr;
        r_ram_wdata <= r_wb_data;
        r_wb_vld    <= 1'b0;
      end
`endif
      else if (w_cpu_grant) begin
        r_ram_en   <= 1'b1;
        r_ram_we   <= bus.cpu_we;
        r_ram_addr <= bus.cpu_addr;
        if (bus.cpu_we) begin
          r_ram_wdata <= bus.cpu_din;
        end
      end

      case (r_cpu_st)
        IDLE: begin
          if (w_cpu_grant) begin
            r_cpu_st <= ISSUED;
            r_cpu_we <= bus.cpu_we;
          end
`ifdef VRAM_ARB_WBUF_EN
          else if (w_wb_post) begin
            r_cpu_st  <= DONE;
            r_cpu_we  <= 1'b1;
            r_wb_vld  <= 1'b1;
            r_wb_addr <= bus.cpu_addr;
            r_wb_data <= bus.cpu_din;
          end
`endif
        end
        ISSUED: r_cpu_st <= DONE;
        DONE: begin
          r_cpu_st  <= IDLE;
          r_cpu_rdy <= 1'b1;
          if (!r_cpu_we) begin
            r_cpu_dout <= bus.ram_rdata;
          end
        end
        default: r_cpu_st <= IDLE;
      endcase
    end
  end

  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.cpu_rdy   = r_cpu_rdy;
  assign bus.cpu_dout  = r_cpu_dout;
  assign bus.vid_valid = r_vid_valid;
  assign bus.vid_dout  = r_vid_dout;

endmodule

// File: tb/tb_vram_arb.sv
// Directed and randomized checks of vram_arb against a schedule-level reference model and RAM model.
module tb_vram_arb;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int NR = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  vram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (.i_clk(clk), .i_reset(reset), .bus(bus));

  function automatic logic [7:0] pat(input int a);
    if (a == 'h123) return 8'h5A;
    return 8'(a * 37 + 11);
  endfunction

  // Synchronous RAM model: read data appears the cycle after ram_en is sampled.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  int nvec = 0;
  int nerr = 0;
  logic [7:0]  shadow [0:(1<<AW)-1];
  logic [7:0]  last_vid, last_rd;
  bit          vs [NR];
  logic [12:0] va [NR];
  int          issue [NR];
  bit          op_act, op_we;
  logic [12:0] op_addr;
  logic [7:0]  op_data, op_exp;
  int          rdy_edge, next_start, wb_drain, e, d, rdy_e;
  bit          exp_vv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ram_en"},    bus.ram_en,    0);
    chk({tag, "_ram_we"},    bus.ram_we,    0);
    chk({tag, "_ram_addr"},  bus.ram_addr,  0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    chk({tag, "_cpu_rdy"},   bus.cpu_rdy,   0);
    chk({tag, "_vid_valid"}, bus.vid_valid, 0);
    chk({tag, "_cpu_dout"},  bus.cpu_dout,  0);
    chk({tag, "_vid_dout"},  bus.vid_dout,  0);
  endtask

  task automatic cpu_read_check(input logic [12:0] a, input logic [7:0] exp, input string tag);
    bit seen;
    seen = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (bus.cpu_rdy) seen = 1'b1;
    end
    bus.cpu_req = 1'b0;
    chk({tag, "_rdy"}, seen, 1);
    chk({tag, "_data"}, bus.cpu_dout, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) shadow[i] = pat(i);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;

    // Reset state
    tick(); tick();
    preload = 1'b0;
    chk_all_zero("reset");
    reset = 1'b0;

    // Quiet bus
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_ram_en", bus.ram_en, 0);
      chk("idle_cpu_rdy", bus.cpu_rdy, 0);
      chk("idle_vid_valid", bus.vid_valid, 0);
    end

    // CPU read on idle bus
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h123;
    tick();
    chk("rd_ram_en", bus.ram_en, 1);
    chk("rd_ram_we", bus.ram_we, 0);
    chk("rd_ram_addr", bus.ram_addr, 13'h123);
    tick();
    chk("rd_rdy_early", bus.cpu_rdy, 0);
    tick();
    chk("rd_rdy", bus.cpu_rdy, 1);
    chk("rd_dout", bus.cpu_dout, 8'h5A);
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_rdy_pulse", bus.cpu_rdy, 0);
    chk("rd_dout_hold", bus.cpu_dout, 8'h5A);

    // Simultaneous CPU and video request: video wins
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h200;
    bus.vid_req = 1'b1; bus.vid_addr = 13'h010;
    tick();
    chk("col_vid_addr", bus.ram_addr, 13'h010);
    chk("col_vid_we", bus.ram_we, 0);
    bus.vid_req = 1'b0;
    tick();
    chk("col_cpu_en", bus.ram_en, 1);
    chk("col_cpu_addr", bus.ram_addr, 13'h200);
    tick();
    chk("col_vid_valid", bus.vid_valid, 1);
    chk("col_vid_dout", bus.vid_dout, pat('h10));
    chk("col_rdy_early", bus.cpu_rdy, 0);
    tick();
    chk("col_rdy", bus.cpu_rdy, 1);
    chk("col_dout", bus.cpu_dout, pat('h200));
    chk("col_vid_pulse", bus.vid_valid, 0);
    bus.cpu_req = 1'b0;
    tick();

    // Ten-cycle video burst with a CPU write pending
`ifdef VRAM_ARB_WBUF_EN
    rdy_e = 1;
`else
    rdy_e = 12;
`endif
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h100; bus.cpu_din = 8'h3C;
    for (int j = 0; j < 14; j++) begin
      bus.vid_req = (j < 10); bus.vid_addr = 13'(j);
      tick();
      chk("burst_ram_we", bus.ram_we, (j == 10));
      if (j == 10) begin
        chk("burst_wr_addr", bus.ram_addr, 13'h100);
        chk("burst_wr_data", bus.ram_wdata, 8'h3C);
      end
      chk("burst_vid_valid", bus.vid_valid, (j >= 2 && j <= 11));
      if (j >= 2 && j <= 11) chk("burst_vid_dout", bus.vid_dout, pat(j - 2));
      chk("burst_cpu_rdy", bus.cpu_rdy, (j == rdy_e));
      if (j == rdy_e) bus.cpu_req = 1'b0;
    end
    bus.cpu_we = 1'b0;
    shadow['h100] = 8'h3C;
    cpu_read_check(13'h100, 8'h3C, "burst_readback");

    // Reset while the CPU access is ISSUED, with a video fetch in flight
    bus.vid_req = 1'b1; bus.vid_addr = 13'd5;
    tick();
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h300;
    tick();
    chk("rst_grant_addr", bus.ram_addr, 13'h300);
    reset = 1'b1; bus.cpu_req = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_rdy", bus.cpu_rdy, 0);
      chk("rst_no_vid", bus.vid_valid, 0);
    end
    last_vid = 8'h00;
    last_rd  = 8'h00;

`ifdef VRAM_ARB_WBUF_EN
    // Posted write during a burst, then read-after-write of the same address
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h1FFF; bus.cpu_din = 8'hA5;
    for (int j = 0; j < 11; j++) begin
      bus.vid_req = (j < 6); bus.vid_addr = 13'(32 + j);
      tick();
      chk("wb_ram_we", bus.ram_we, (j == 6));
      if (j == 6) begin
        chk("wb_wr_addr", bus.ram_addr, 13'h1FFF);
        chk("wb_wr_data", bus.ram_wdata, 8'hA5);
      end
      chk("wb_vid_valid", bus.vid_valid, (j >= 2 && j <= 7));
      chk("wb_cpu_rdy", bus.cpu_rdy, (j == 1 || j == 9));
      if (j == 9) chk("wb_raw_data", bus.cpu_dout, 8'hA5);
      if (j == 1 || j == 9) bus.cpu_req = 1'b0;
      if (j == 2) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
      end
    end
    shadow['h1FFF] = 8'hA5;
    last_vid = pat(37);
    last_rd  = 8'hA5;
`endif

    // Randomized traffic against the schedule model
    for (int t = 0; t < NR; t++) begin
      vs[t] = (t < NR - 16) ? ($urandom_range(0, 99) < 55) : 1'b0;
      va[t] = 13'($urandom_range(0, 63));
      issue[t] = 0;
    end
    op_act = 1'b0; next_start = 2; wb_drain = -1; rdy_edge = -1;
    op_we = 1'b0; op_addr = '0; op_data = '0; op_exp = '0;
    for (int t = 0; t < NR; t++) begin
      bus.vid_req = vs[t]; bus.vid_addr = va[t];
      if (!op_act && t == next_start && t < NR - 20) begin
        op_we   = 1'($urandom_range(0, 1));
        op_addr = 13'h1000 + 13'($urandom_range(0, 15));
        op_data = 8'($urandom);
        e = t;
`ifdef VRAM_ARB_WBUF_EN
        while (e <= wb_drain || (!op_we && vs[e])) e++;
        if (op_we) begin
          rdy_edge = e + 1;
          d = e + 1;
          while (vs[d]) d++;
          issue[d] = 2;
          wb_drain = d;
        end else begin
          issue[e] = 1;
          rdy_edge = e + 2;
        end
`else
        while (vs[e]) e++;
        issue[e] = op_we ? 2 : 1;
        rdy_edge = e + 2;
`endif
        op_exp = shadow[op_addr];
        if (op_we) shadow[op_addr] = op_data;
        bus.cpu_req = 1'b1; bus.cpu_we = op_we; bus.cpu_addr = op_addr; bus.cpu_din = op_data;
        op_act = 1'b1;
      end
      tick();
      chk("rnd_ram_en", bus.ram_en, (vs[t] || issue[t] != 0));
      chk("rnd_ram_we", bus.ram_we, (!vs[t] && issue[t] == 2));
      if (vs[t]) chk("rnd_ram_addr", bus.ram_addr, va[t]);
      exp_vv = (t >= 2) ? vs[t - 2] : 1'b0;
      chk("rnd_vid_valid", bus.vid_valid, exp_vv);
      if (exp_vv) last_vid = shadow[va[t - 2]];
      chk("rnd_vid_dout", bus.vid_dout, last_vid);
      chk("rnd_cpu_rdy", bus.cpu_rdy, (op_act && t == rdy_edge));
      if (op_act && t == rdy_edge) begin
        if (!op_we) last_rd = op_exp;
        op_act = 1'b0;
        bus.cpu_req = 1'b0;
        next_start = t + 2 + $urandom_range(0, 3);
      end
      chk("rnd_cpu_dout", bus.cpu_dout, last_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the VRAM address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the VRAM data width.
REQ-003 clk  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 cpu_req  in  1  SHALL be the CPU access request, held high until cpu_rdy.
REQ-006 cpu_we  in  1  SHALL mark the CPU access as a write (1) or a read (0).
REQ-007 cpu_addr  in  ADDR_W  SHALL be the CPU address.
REQ-008 cpu_din  in  DATA_W  SHALL be the CPU write data.
REQ-009 cpu_dout  out  DATA_W  SHALL be the CPU read data, valid while cpu_rdy is high.
REQ-010 cpu_rdy  out  1  SHALL be a one-cycle completion pulse.
REQ-011 vid_req  in  1  SHALL be the scanout fetch request; one read per cycle is allowed; it cannot be stalled.
REQ-012 vid_addr  in  ADDR_W  SHALL be the scanout fetch address.
REQ-013 vid_dout  out  DATA_W  SHALL be the scanout read data, valid while vid_valid is high.
REQ-014 vid_valid  out  1  SHALL be a one-cycle pulse per fetch.
REQ-015 ram_en, ram_we  out  1 each  SHALL be the registered RAM enable and write strobe.
REQ-016 ram_addr  out  ADDR_W  SHALL be the registered RAM address.
REQ-017 ram_wdata  out  DATA_W  SHALL be the registered RAM write data.
REQ-018 ram_rdata  in  DATA_W  SHALL be the RAM read data, valid the cycle after the RAM samples ram_en.

Function
REQ-019 The arbiter SHALL grant at most one RAM access per clock edge; vid_req SHALL have absolute priority.
REQ-020 A video request sampled at edge k SHALL drive ram_en=1, ram_we=0, ram_addr=vid_addr after edge k.
REQ-021 For that video request, vid_valid=1 and vid_dout=ram_rdata SHALL follow edge k+2.
REQ-022 Video requests SHALL be fully pipelined, so back-to-back requests produce back-to-back vid_valid pulses in order.
REQ-023 The CPU engine SHALL have the states IDLE, ISSUED and DONE.
REQ-024 cpu_req SHALL be sampled only in IDLE.
REQ-025 IDLE->ISSUED SHALL occur at an edge where cpu_req=1 and vid_req=0; the RAM port is driven with the CPU access after that edge.
REQ-026 ISSUED->DONE SHALL be unconditional; in DONE, cpu_rdy=1 and, for a read, cpu_dout=ram_rdata.
REQ-027 DONE->IDLE SHALL be unconditional; the requester drops cpu_req before the DONE->IDLE edge.
REQ-028 CPU latency SHALL be grant edge +2 edges; a CPU request waits while vid_req=1, for an unbounded time.
REQ-029 On simultaneous cpu_req and vid_req, video SHALL win and the CPU SHALL be granted at the first edge with vid_req=0.
REQ-030 On any cycle with no grant, ram_en and ram_we SHALL both be 0.
REQ-031 cpu_dout SHALL hold its last read value outside DONE; vid_dout SHALL hold its last value when vid_valid=0.

Reset
REQ-032 While reset=1 at an edge, the block SHALL clear the CPU state to IDLE and flush the video pipeline.
REQ-033 That same reset SHALL drive ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_rdy=0, vid_valid=0, cpu_dout=0 and vid_dout=0.
REQ-034 Accesses in flight at reset SHALL be discarded; no cpu_rdy or vid_valid pulse SHALL be produced for them.

Configuration
REQ-035 With VRAM_ARB_WBUF_EN defined, a CPU write SHALL be posted into a one-entry write buffer.
REQ-036 A posted write SHALL produce cpu_rdy after the accept edge k+1.
REQ-037 The buffered write SHALL issue at the first edge with vid_req=0.
REQ-038 With the write buffer full, new CPU writes and reads SHALL NOT be accepted until the buffer drains, so read-after-write returns the new data.
REQ-039 With VRAM_ARB_WBUF_EN undefined, writes SHALL follow the read timing of REQ-023 to REQ-027 and no buffer SHALL exist.

Verification
REQ-040 Idle bus, RAM[0x0123]=0x5A, CPU read at edge k -> ram_en=1 after k; cpu_rdy=1 and cpu_dout=0x5A after k+2, for one cycle.
REQ-041 cpu_req and vid_req (addr 0x0010) together at edge k -> vid_valid after k+2; CPU granted at k+1; cpu_rdy after k+3.
REQ-042 vid_req high for 10 cycles at addresses 0..9 with a CPU write pending -> 10 consecutive in-order vid_valid pulses, no ram_we during the burst, and the write issued at the first edge with vid_req low.
REQ-043 reset asserted while the CPU engine is in ISSUED -> no cpu_rdy pulse, and all outputs zero after the reset edge.
REQ-044 WBUF_EN: write 0xA5 to 0x1FFF during a video burst -> cpu_rdy after k+1 and ram_we after the burst; an immediately following read of 0x1FFF returns 0xA5.
REQ-045 No requests for 20 cycles -> ram_en=0, cpu_rdy=0 and vid_valid=0 throughout.
